mpu6050_seq_ctrl: RTL and testbench



---
 rtl/mpu6050_seq_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_mpu6050_seq_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu6050_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mpu6050_seq_ctrl
//
// Purpose:
//   Sequencer that owns the register-select/start interface of the I2C master
//   wrapper. When enabled, it brings up the MPU6050 in four steps: device
//   reset, a settle wait, wake, and a WHO_AM_I check. After that it runs a
//   periodic 12-byte accel/gyro burst. Each complete burst is assembled into
//   six signed 16-bit samples, which are published with a one-cycle valid
//   pulse.
//
// Ports:
//   clk_50        in   system clock
//   rst           in   synchronous active-high reset
//   en            in   run enable (level)
//   cmd_start     out  one-cycle request to the I2C master
//   cmd_sel       out  [3:0] register selector, stable until cmd_done
//   cmd_busy      in   master busy
//   cmd_done      in   one-cycle transaction-complete pulse
//   cmd_nack      in   slave NACK, qualified by cmd_done
//   rd_data       in   [7:0] read byte, qualified by cmd_done
//   accel_x/y/z   out  [15:0] signed accelerometer samples
//   gyro_x/y/z    out  [15:0] signed gyro samples
//   sample_valid  out  one-cycle pulse when all six samples update
//   init_done     out  bring-up succeeded, cleared by en low or error
//   err           out  sticky error
//   err_code      out  [1:0] 0 none, 1 retries exhausted, 2 WHO_AM_I mismatch
//   overrun       out  sticky: a sample tick hit an in-progress burst
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module mpu6050_seq_ctrl #(
  parameter int          SAMPLE_DIV     = 500000,
  parameter int          RESET_WAIT_CYC = 5000000,
  parameter int          TIMEOUT_CYC    = 100000,
  parameter int          MAX_RETRY      = 3,
  parameter logic [7:0]  WHO_AM_I_VAL   = 8'h68
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        en,
  output logic        cmd_start,
  output logic [3:0]  cmd_sel,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  input  logic        cmd_nack,
  input  logic [7:0]  rd_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        init_done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        overrun
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV + 1);
  localparam int WAIT_W = $clog2(RESET_WAIT_CYC + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int RTRY_W = $clog2(MAX_RETRY + 2);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(RESET_WAIT_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTRY_W-1:0] RETRY_LAST = RTRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_OFF,
    S_DEV_RST,
    S_RST_WAIT,
    S_WAKE,
    S_WHOAMI,
    S_IDLE,
    S_BURST,
    S_PUBLISH,
    S_ERROR
  } state_t;

  state_t             state_q,        state_d;
  logic               pend_q,         pend_d;
  logic [TO_W-1:0]    timer_q,        timer_d;
  logic [RTRY_W-1:0]  retry_q,        retry_d;
  logic [WAIT_W-1:0]  wait_q,         wait_d;
  logic [DIV_W-1:0]   div_q,          div_d;
  logic [3:0]         idx_q,          idx_d;
  logic [95:0]        buf_q,          buf_d;
  logic               cmd_start_q,    cmd_start_d;
  logic [3:0]         cmd_sel_q,      cmd_sel_d;
  logic [15:0]        accel_x_q,      accel_x_d;
  logic [15:0]        accel_y_q,      accel_y_d;
  logic [15:0]        accel_z_q,      accel_z_d;
  logic [15:0]        gyro_x_q,       gyro_x_d;
  logic [15:0]        gyro_y_q,       gyro_y_d;
  logic [15:0]        gyro_z_q,       gyro_z_d;
  logic               sample_valid_q, sample_valid_d;
  logic               init_done_q,    init_done_d;
  logic               err_q,          err_d;
  logic [1:0]         err_code_q,     err_code_d;
  logic               overrun_q,      overrun_d;

  logic               tick;
  logic               go_off;
  logic [3:0]         cmd_code;

  // Selector for the command belonging to the current state. Burst reads
  // walk 0x4..0xF following the byte index.
  always_comb begin
    cmd_code = 4'h0;
    case (state_q)
      S_DEV_RST: cmd_code = 4'h2;
      S_WAKE:    cmd_code = 4'h3;
      S_WHOAMI:  cmd_code = 4'h1;
      S_BURST:   cmd_code = 4'h4 + idx_q;
      default:   cmd_code = 4'h0;
    endcase
  end

  // Next-state logic. Every command state shares the same issue/wait/retry
  // handshake. pend_q separates "waiting to issue" from "waiting for done".
  // A transaction in flight is always allowed to finish (done or timeout)
  // before the enable drop is honoured.
  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    timer_d        = timer_q;
    retry_d        = retry_q;
    wait_d         = wait_q;
    div_d          = div_q;
    idx_d          = idx_q;
    buf_d          = buf_q;
    cmd_start_d    = 1'b0;
    cmd_sel_d      = cmd_sel_q;
    accel_x_d      = accel_x_q;
    accel_y_d      = accel_y_q;
    accel_z_d      = accel_z_q;
    gyro_x_d       = gyro_x_q;
    gyro_y_d       = gyro_y_q;
    gyro_z_d       = gyro_z_q;
    sample_valid_d = 1'b0;
    init_done_d    = init_done_q;
    err_d          = err_q;
    err_code_d     = err_code_q;
    overrun_d      = overrun_q;
    go_off         = 1'b0;

    tick = (div_q == DIV_LAST);

    // The sample divider runs only once the device is up. It is parked at
    // zero everywhere else, so the first tick lands a full period after
    // bring-up.
    if (state_q == S_IDLE || state_q == S_BURST || state_q == S_PUBLISH) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end else begin
      div_d = '0;
    end

    // A tick that arrives before the previous burst has been published is
    // dropped and only flagged.
    if (tick && (state_q == S_BURST || state_q == S_PUBLISH)) begin
      overrun_d = 1'b1;
    end

    if (!en) begin
      init_done_d = 1'b0;
    end

    case (state_q)
      S_OFF: begin
        if (en) begin
          state_d = S_DEV_RST;
        end
      end

      S_RST_WAIT: begin
        if (!en) begin
          go_off = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_WAKE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_IDLE: begin
        if (!en) begin
          go_off = 1'b1;
        end else if (tick) begin
          idx_d   = 4'd0;
          state_d = S_BURST;
        end
      end

      S_PUBLISH: begin
        if (!en) begin
          go_off = 1'b1;
        end else begin
          // Byte 2k is the high byte and byte 2k+1 the low byte of sample k.
          accel_x_d      = {buf_q[7:0],   buf_q[15:8]};
          accel_y_d      = {buf_q[23:16], buf_q[31:24]};
          accel_z_d      = {buf_q[39:32], buf_q[47:40]};
          gyro_x_d       = {buf_q[55:48], buf_q[63:56]};
          gyro_y_d       = {buf_q[71:64], buf_q[79:72]};
          gyro_z_d       = {buf_q[87:80], buf_q[95:88]};
          sample_valid_d = 1'b1;
          state_d        = S_IDLE;
        end
      end

      S_ERROR: begin
        if (!en) begin
          go_off = 1'b1;
        end
      end

      S_DEV_RST, S_WAKE, S_WHOAMI, S_BURST: begin
        if (!pend_q) begin
          if (!en) begin
            go_off = 1'b1;
          end else if (!cmd_busy) begin
            cmd_start_d = 1'b1;
            cmd_sel_d   = cmd_code;
            pend_d      = 1'b1;
            timer_d     = '0;
          end
        end else begin
          timer_d = timer_q + TO_W'(1);
          if (cmd_done || timer_q == TO_LAST) begin
            pend_d = 1'b0;
            if (!en) begin
              go_off = 1'b1;
            end else if (cmd_done && !cmd_nack) begin
              retry_d = '0;
              case (state_q)
                S_DEV_RST: begin
                  wait_d  = '0;
                  state_d = S_RST_WAIT;
                end
                S_WAKE: begin
                  state_d = S_WHOAMI;
                end
                S_WHOAMI: begin
                  if (rd_data == WHO_AM_I_VAL) begin
                    init_done_d = 1'b1;
                    div_d       = '0;
                    state_d     = S_IDLE;
                  end else begin
                    // A wrong identity is not a bus problem, so no retry.
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    err_code_d  = 2'd2;
                    init_done_d = 1'b0;
                  end
                end
                S_BURST: begin
                  buf_d[{idx_q, 3'b000} +: 8] = rd_data;
                  if (idx_q == 4'd11) begin
                    state_d = S_PUBLISH;
                  end else begin
                    idx_d = idx_q + 4'd1;
                  end
                end
                default: begin
                  state_d = S_OFF;
                end
              endcase
            end else if (retry_q == RETRY_LAST) begin
              state_d     = S_ERROR;
              err_d       = 1'b1;
              err_code_d  = 2'd1;
              init_done_d = 1'b0;
              retry_d     = '0;
            end else begin
              retry_d = retry_q + RTRY_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = S_OFF;
      end
    endcase

    // Returning to OFF clears all status. The sample outputs are
    // deliberately left alone.
    if (go_off) begin
      state_d     = S_OFF;
      pend_d      = 1'b0;
      timer_d     = '0;
      retry_d     = '0;
      wait_d      = '0;
      idx_d       = 4'd0;
      init_done_d = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'd0;
      overrun_d   = 1'b0;
    end
  end

  // State and output registers. The reset is synchronous and does not wait
  // for an outstanding master transaction.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q        <= S_OFF;
      pend_q         <= 1'b0;
      timer_q        <= '0;
      retry_q        <= '0;
      wait_q         <= '0;
      div_q          <= '0;
      idx_q          <= 4'd0;
      buf_q          <= '0;
      cmd_start_q    <= 1'b0;
      cmd_sel_q      <= 4'h0;
      accel_x_q      <= 16'h0;
      accel_y_q      <= 16'h0;
      accel_z_q      <= 16'h0;
      gyro_x_q       <= 16'h0;
      gyro_y_q       <= 16'h0;
      gyro_z_q       <= 16'h0;
      sample_valid_q <= 1'b0;
      init_done_q    <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 2'd0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      wait_q         <= wait_d;
      div_q          <= div_d;
      idx_q          <= idx_d;
      buf_q          <= buf_d;
      cmd_start_q    <= cmd_start_d;
      cmd_sel_q      <= cmd_sel_d;
      accel_x_q      <= accel_x_d;
      accel_y_q      <= accel_y_d;
      accel_z_q      <= accel_z_d;
      gyro_x_q       <= gyro_x_d;
      gyro_y_q       <= gyro_y_d;
      gyro_z_q       <= gyro_z_d;
      sample_valid_q <= sample_valid_d;
      init_done_q    <= init_done_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      overrun_q      <= overrun_d;
    end
  end

  assign cmd_start    = cmd_start_q;
  assign cmd_sel      = cmd_sel_q;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign gyro_x       = gyro_x_q;
  assign gyro_y       = gyro_y_q;
  assign gyro_z       = gyro_z_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mpu6050_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mpu6050_seq_ctrl
//
// Purpose:
//   Self-checking bench for mpu6050_seq_ctrl. A behavioural I2C master/slave
//   model answers every cmd_start after a programmable latency. The answer
//   can be a programmable number of NACKs, no answer at all, or data bytes
//   that are fixed or random. Whenever the model completes the last burst
//   byte it pushes the expected six samples into a scoreboard queue, and a
//   separate monitor pops and compares on every sample_valid.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mpu6050_seq_ctrl;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        en;
  logic        cmd_start;
  logic [3:0]  cmd_sel;
  logic        cmd_busy;
  logic        cmd_done;
  logic        cmd_nack;
  logic [7:0]  rd_data;
  logic [15:0] accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z;
  logic        sample_valid;
  logic        init_done;
  logic        err;
  logic [1:0]  err_code;
  logic        overrun;

  int testsRun = 0;
  int failures = 0;
  int cycle    = 0;

  // Slave model configuration, written by the main sequence
  int          latency    = 20;
  bit          noDone     = 1'b0;
  bit          fixedBytes = 1'b0;
  logic [7:0]  whoAmIVal  = 8'h68;
  int          nackLeft [16];

  // Slave model state and logs
  int          countdown  = 0;
  int          curSel     = 0;
  int          lastSel    = 0;
  int          burstBytes [12];
  int          startLog [$];
  int          startCyc [$];
  logic [95:0] expQ [$];
  logic [95:0] lastExp    = '0;
  int          pulseCount = 0;
  int          pulseCyc [$];

  mpu6050_seq_ctrl #(
    .SAMPLE_DIV     (2000),
    .RESET_WAIT_CYC (100),
    .TIMEOUT_CYC    (500),
    .MAX_RETRY      (3),
    .WHO_AM_I_VAL   (8'h68)
  ) dut (
    .clk_50       (clk_50),
    .rst          (rst),
    .en           (en),
    .cmd_start    (cmd_start),
    .cmd_sel      (cmd_sel),
    .cmd_busy     (cmd_busy),
    .cmd_done     (cmd_done),
    .cmd_nack     (cmd_nack),
    .rd_data      (rd_data),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .gyro_x       (gyro_x),
    .gyro_y       (gyro_y),
    .gyro_z       (gyro_z),
    .sample_valid (sample_valid),
    .init_done    (init_done),
    .err          (err),
    .err_code     (err_code),
    .overrun      (overrun)
  );

  // 50 MHz clock
  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    failures++;
    $display("[TB] FAIL %s: wait expired, condition never reached", name);
  endtask

  task automatic applyStimulus(input logic enVal);
    @(negedge clk_50);
    en = enVal;
  endtask

  task automatic resetDut();
    @(negedge clk_50);
    rst        = 1'b1;
    en         = 1'b0;
    latency    = 20;
    noDone     = 1'b0;
    fixedBytes = 1'b0;
    whoAmIVal  = 8'h68;
    for (int i = 0; i < 16; i++) nackLeft[i] = 0;
    repeat (5) @(negedge clk_50);
    rst = 1'b0;
    startLog.delete();
    startCyc.delete();
    expQ.delete();
  endtask

  // mode 0: init_done or err, 1: err, 2: pulseCount >= target, 3: sel 0x7 issued
  task automatic waitUntil(input string name, input int budget, input int mode,
                           input int target);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk_50);
      n++;
      case (mode)
        0:       hit = init_done || err;
        1:       hit = err;
        2:       hit = (pulseCount >= target);
        default: hit = (lastSel == 7);
      endcase
    end
    if (!hit) reportTimeout(name);
  endtask

  function automatic int countSel(input int sel, input int fromIdx);
    int c;
    c = 0;
    for (int i = fromIdx; i < startLog.size(); i++) begin
      if (startLog[i] == sel) c++;
    end
    return c;
  endfunction

  // Behavioural master + slave. Each cmd_start makes the master busy for
  // 'latency' cycles, after which a done pulse carries either a NACK or a
  // byte. The expected samples come straight from the byte stream:
  // sample k = byte(2k) * 256 + byte(2k+1).
  initial begin
    logic [95:0] v;
    int          d;
    cmd_busy = 1'b0;
    cmd_done = 1'b0;
    cmd_nack = 1'b0;
    rd_data  = 8'h00;
    forever begin
      @(negedge clk_50);
      cmd_done = 1'b0;
      cmd_nack = 1'b0;
      if (rst) begin
        countdown = 0;
        cmd_busy  = 1'b0;
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            cmd_busy = 1'b0;
            cmd_done = 1'b1;
            if (nackLeft[curSel] > 0) begin
              nackLeft[curSel]--;
              cmd_nack = 1'b1;
            end else begin
              if (curSel == 1)      d = int'(whoAmIVal);
              else if (curSel >= 4) d = fixedBytes ? (curSel - 3) : int'($urandom_range(0, 255));
              else                  d = 0;
              rd_data = 8'(d);
              if (curSel >= 4) burstBytes[curSel - 4] = d;
              if (curSel == 15) begin
                for (int k = 0; k < 6; k++)
                  v[16*k +: 16] = 16'(burstBytes[2*k] * 256 + burstBytes[2*k+1]);
                expQ.push_back(v);
              end
            end
          end
        end
        if (cmd_start) begin
          curSel  = int'(cmd_sel);
          lastSel = curSel;
          startLog.push_back(curSel);
          startCyc.push_back(cycle);
          if (!noDone) begin
            cmd_busy  = 1'b1;
            countdown = latency;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every sample_valid must match the oldest expected burst
  initial begin
    logic [95:0] e;
    logic [15:0] act [6];
    forever begin
      @(negedge clk_50);
      if (sample_valid) begin
        pulseCount++;
        pulseCyc.push_back(cycle);
        if (expQ.size() == 0) begin
          testsRun++;
          failures++;
          $display("[TB] FAIL sample_unexpected: got a pulse, expected none");
        end else begin
          e       = expQ.pop_front();
          lastExp = e;
          act     = '{accel_x, accel_y, accel_z, gyro_x, gyro_y, gyro_z};
          for (int k = 0; k < 6; k++)
            checkOutput($sformatf("sample_%0d", k), 32'(act[k]), 32'(e[16*k +: 16]));
        end
      end
    end
  end

  initial begin
    #(20 * 80000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, p0, l0;
    rst = 1'b1;
    en  = 1'b0;

    // Reset state
    resetDut();
    @(negedge clk_50);
    checkOutput("rst_cmd_start", 32'(cmd_start), 0);
    checkOutput("rst_cmd_sel", 32'(cmd_sel), 0);
    checkOutput("rst_flags", {28'd0, init_done, err, overrun, sample_valid}, 0);
    checkOutput("rst_err_code", 32'(err_code), 0);
    checkOutput("rst_accel_x", 32'(accel_x), 0);

    // Bring-up, then fixed-pattern bursts
    fixedBytes = 1'b1;
    applyStimulus(1'b1);
    waitUntil("bringup", 2000, 0, 0);
    checkOutput("bringup_count", startLog.size(), 3);
    checkOutput("bringup_sel0", startLog[0], 2);
    checkOutput("bringup_sel1", startLog[1], 3);
    checkOutput("bringup_sel2", startLog[2], 1);
    checkOutput("bringup_init_done", 32'(init_done), 1);
    checkOutput("bringup_err", 32'(err), 0);
    waitUntil("burst_first", 3000, 2, 1);
    checkOutput("burst_accel_x", 32'(accel_x), 32'h0102);
    checkOutput("burst_accel_y", 32'(accel_y), 32'h0304);
    checkOutput("burst_accel_z", 32'(accel_z), 32'h0506);
    checkOutput("burst_gyro_x", 32'(gyro_x), 32'h0708);
    checkOutput("burst_gyro_y", 32'(gyro_y), 32'h090A);
    checkOutput("burst_gyro_z", 32'(gyro_z), 32'h0B0C);
    waitUntil("burst_second", 2500, 2, 2);
    if (pulseCyc.size() >= 2)
      checkOutput("burst_period", pulseCyc[1] - pulseCyc[0], 2000);
    fixedBytes = 1'b0;
    waitUntil("burst_random", 7000, 2, 5);
    checkOutput("burst_overrun", 32'(overrun), 0);

    // Two WAKE NACKs then success
    resetDut();
    nackLeft[3] = 2;
    applyStimulus(1'b1);
    waitUntil("nack2", 2000, 0, 0);
    checkOutput("nack2_wake_count", countSel(3, 0), 3);
    checkOutput("nack2_init_done", 32'(init_done), 1);
    checkOutput("nack2_err", 32'(err), 0);

    // WAKE NACKs exhaust the retries
    resetDut();
    nackLeft[3] = 10;
    applyStimulus(1'b1);
    waitUntil("nack4", 2000, 1, 0);
    checkOutput("nack4_wake_count", countSel(3, 0), 4);
    checkOutput("nack4_err_code", 32'(err_code), 1);
    s0 = startLog.size();
    repeat (1000) @(negedge clk_50);
    checkOutput("nack4_quiet", startLog.size(), s0);
    checkOutput("nack4_err_hold", 32'(err), 1);

    // Leave ERROR through en low, then re-enable from DEV_RST
    applyStimulus(1'b0);
    repeat (5) @(negedge clk_50);
    checkOutput("off_err_cleared", {30'd0, err, err_code != 2'd0}, 0);
    nackLeft[3] = 0;
    s0 = startLog.size();
    applyStimulus(1'b1);
    waitUntil("reenable", 2000, 0, 0);
    if (startLog.size() > s0) checkOutput("reenable_first_sel", startLog[s0], 2);
    else reportTimeout("reenable_first_sel");
    checkOutput("reenable_init_done", 32'(init_done), 1);

    // WHO_AM_I mismatch
    resetDut();
    whoAmIVal = 8'h72;
    applyStimulus(1'b1);
    waitUntil("mismatch", 2000, 1, 0);
    checkOutput("mismatch_whoami_count", countSel(1, 0), 1);
    checkOutput("mismatch_err_code", 32'(err_code), 2);
    checkOutput("mismatch_init_done", 32'(init_done), 0);

    // Master never completes: retries on timeout
    resetDut();
    noDone = 1'b1;
    applyStimulus(1'b1);
    waitUntil("timeout", 4000, 1, 0);
    checkOutput("timeout_count", startLog.size(), 4);
    checkOutput("timeout_sel", countSel(2, 0), 4);
    checkOutput("timeout_err_code", 32'(err_code), 1);
    if (startCyc.size() >= 2)
      checkOutput("timeout_spacing",
                  32'((startCyc[1] - startCyc[0] >= 495) && (startCyc[1] - startCyc[0] <= 505)), 1);

    // Slow master: each burst takes longer than a sample period
    resetDut();
    latency = 200;
    applyStimulus(1'b1);
    waitUntil("slow_bringup", 2000, 0, 0);
    p0 = pulseCount;
    waitUntil("slow_bursts", 12000, 2, p0 + 2);
    checkOutput("slow_overrun", 32'(overrun), 1);
    checkOutput("slow_queue_empty", expQ.size(), 0);

    // Drop en in the middle of a burst
    latency = 20;
    lastSel = 0;
    waitUntil("disable_midburst", 6000, 3, 0);
    p0 = pulseCount;
    l0 = startLog.size();
    applyStimulus(1'b0);
    repeat (3000) @(negedge clk_50);
    checkOutput("disable_no_pulse", pulseCount, p0);
    checkOutput("disable_no_start", startLog.size(), l0);
    checkOutput("disable_flags", {29'd0, init_done, err, overrun}, 0);
    checkOutput("disable_err_code", 32'(err_code), 0);
    checkOutput("disable_hold_accel_x", 32'(accel_x), 32'(lastExp[15:0]));
    checkOutput("disable_hold_gyro_z", 32'(gyro_z), 32'(lastExp[95:80]));

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
